// File: rtl/fp32_div_seq.sv
// fp32_div_seq -- sequential IEEE-754 single-precision divider.
//
// Radix-2 restoring mantissa divider behind a start/done handshake. The
// latency is fixed: done pulses in the 28th cycle after the edge that
// accepts start, including for special operands (NaN, inf, zero).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts an operation in flight
//   start        request; sampled only while busy=0
//   inp1         dividend, IEEE-754 single
//   inp2         divisor, IEEE-754 single
//   busy         high while an operation is in flight
//   done         one-cycle pulse; out and flags valid from this cycle
//   out          quotient, held until the next done
//   underflow    result flushed to signed zero
//   overflow     finite result saturated to signed infinity
//   div_by_zero  finite nonzero divided by zero
//
// Configuration macro:
//   FP32_DIV_RNE_EN  defined   -> round-to-nearest-even
//                    undefined -> truncation (matches the fp32 multiplier)

module fp32_div_seq #(
    parameter int ITER = 26  // quotient bits; only 26 is supported
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inp1,
    input  logic [31:0] inp2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        underflow,
    output logic        overflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        accept;
    logic [4:0]  cnt;

    // Operand fields.
    logic       s1, s2;
    logic [7:0] e1, e2;
    logic [22:0] m1, m2;

    // Operation context captured on accept.
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [24:0]        rem_q;
    logic [24:0]        div_q;
    logic [25:0]        quo_q;
    logic               special_q;
    logic [31:0]        special_out_q;
    logic               special_dbz_q;

    // Classification of the incoming operands.
    logic        special_c;
    logic [31:0] special_out_c;
    logic        special_dbz_c;
    logic signed [9:0] exp_c;

    // One restoring step.
    logic        q_bit;
    logic [24:0] rem_sub;
    logic [24:0] rem_nxt;

    // Normalised / rounded result.
    logic [22:0]       mant;
    logic signed [9:0] exp_n;
    logic [31:0]       norm_out;
    logic              norm_ovf;
    logic              norm_unf;

    assign accept = (state == IDLE) && start;

    assign s1 = inp1[31];
    assign e1 = inp1[30:23];
    assign m1 = inp1[22:0];
    assign s2 = inp2[31];
    assign e2 = inp2[30:23];
    assign m2 = inp2[22:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = DIVIDE;
            DIVIDE: if (cnt == 5'(ITER - 1)) state_nxt = NORM;
            NORM:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Operand classification; priority order decides overlapping cases
    // such as inf/0 (inf wins) and 0/inf (zero either way).
    // ------------------------------------------------------------------
    always_comb begin
        logic z1, z2, i1, i2, n1, n2, sgn;
        z1  = (e1 == 8'd0);                       // denormals flush to zero
        z2  = (e2 == 8'd0);
        i1  = (e1 == 8'hFF) && (m1 == 23'd0);
        i2  = (e2 == 8'hFF) && (m2 == 23'd0);
        n1  = (e1 == 8'hFF) && (m1 != 23'd0);
        n2  = (e2 == 8'hFF) && (m2 != 23'd0);
        sgn = s1 ^ s2;

        special_c     = 1'b1;
        special_out_c = 32'h7FC0_0000;
        special_dbz_c = 1'b0;
        if (n1 || n2 || (z1 && z2) || (i1 && i2)) begin
            special_out_c = 32'h7FC0_0000;
        end else if (i1) begin
            special_out_c = {sgn, 8'hFF, 23'd0};
        end else if (i2 || z1) begin
            special_out_c = {sgn, 31'd0};
        end else if (z2) begin
            special_out_c = {sgn, 8'hFF, 23'd0};
            special_dbz_c = 1'b1;
        end else begin
            special_c = 1'b0;
        end
    end

    assign exp_c = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;

    // ------------------------------------------------------------------
    // Restoring division step. The remainder stays below the divisor
    // (< 2^24) after subtraction, so the left shift never loses a bit.
    // ------------------------------------------------------------------
    assign q_bit   = (rem_q >= div_q);
    assign rem_sub = q_bit ? (rem_q - div_q) : rem_q;
    assign rem_nxt = rem_sub << 1;

    // ------------------------------------------------------------------
    // Normalisation, rounding and range check. The quotient of two
    // mantissas in [1,2) lies in (0.5,2), so at most one shift is needed.
    // ------------------------------------------------------------------
    always_comb begin
`ifdef FP32_DIV_RNE_EN
        logic        guard, sticky;
        logic [23:0] mant_inc;
`endif
        if (quo_q[25]) begin
            mant  = quo_q[24:2];
            exp_n = exp_q;
        end else begin
            mant  = quo_q[23:1];
            exp_n = exp_q - 10'sd1;
        end

`ifdef FP32_DIV_RNE_EN
        guard  = quo_q[25] ? quo_q[1] : quo_q[0];
        sticky = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
        mant_inc = {1'b0, mant} + 24'd1;
        if (guard && (sticky || mant[0])) begin
            // Carry out of 1.mant means the value became 2.0.
            if (mant_inc[23]) begin
                mant  = 23'd0;
                exp_n = exp_n + 10'sd1;
            end else begin
                mant = mant_inc[22:0];
            end
        end
`endif

        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (exp_n >= 10'sd255) begin
            norm_out = {sign_q, 8'hFF, 23'd0};
            norm_ovf = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            norm_out = {sign_q, 31'd0};
            norm_unf = 1'b1;
        end else begin
            norm_out = {sign_q, exp_n[7:0], mant};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. These are always initialised by an accepted
    // start before they are read, so they carry no reset.
    // NOTE: sequential state uses non-blocking assignments only; datapath registers are deliberately left without reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q        <= s1 ^ s2;
            exp_q         <= exp_c;
            rem_q         <= {1'b0, 1'b1, m1};
            div_q         <= {1'b0, 1'b1, m2};
            quo_q         <= 26'd0;
            cnt           <= 5'd0;
            special_q     <= special_c;
            special_out_q <= special_out_c;
            special_dbz_q <= special_dbz_c;
        end else if (state == DIVIDE) begin
            rem_q <= rem_nxt;
            quo_q <= {quo_q[24:0], q_bit};
            cnt   <= cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: out holds until the next done; flags clear on
    // every accepted start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            out         <= 32'd0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                underflow   <= 1'b0;
                overflow    <= 1'b0;
                div_by_zero <= 1'b0;
            end else if (state == NORM) begin
                done <= 1'b1;
                if (special_q) begin
                    out         <= special_out_q;
                    div_by_zero <= special_dbz_q;
                end else begin
                    out       <= norm_out;
                    overflow  <= norm_ovf;
                    underflow <= norm_unf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp32_div_seq.sv
// tb_fp32_div_seq -- self-checking bench for fp32_div_seq.
// Directed vectors, handshake corner cases and randomised operands
// compared against an integer-division reference model.

module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] inp1 = 32'd0;
    logic [31:0] inp2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        underflow;
    logic        overflow;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int LATENCY = 28;

    fp32_div_seq #(.ITER(26)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .inp1        (inp1),
        .inp2        (inp2),
        .busy        (busy),
        .done        (done),
        .out         (out),
        .underflow   (underflow),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: returns {div_by_zero, overflow, underflow, out}.
    // Mantissa quotient obtained by one wide integer division.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb;
        logic        za, zb, ia, ib, na, nb;
        longint unsigned num, den, q, r, keep;
        logic        g, st;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        ma = a[22:0];  mb = b[22:0];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
        na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
        if (na || nb || (za && zb) || (ia && ib)) return {3'b000, 32'h7FC00000};
        if (ia) return {3'b000, s, 8'hFF, 23'd0};
        if (ib) return {3'b000, s, 31'd0};
        if (za) return {3'b000, s, 31'd0};
        if (zb) return {3'b100, s, 8'hFF, 23'd0};
        num = longint'({1'b1, ma}) << 26;
        den = longint'({1'b1, mb});
        q = num / den;
        r = num % den;
        e = int'(ea) - int'(eb) + 127;
        if (q >= (64'd1 << 26)) begin
            keep = q >> 3;
            g    = q[2];
            st   = (q[1:0] != 0) || (r != 0);
        end else begin
            e    = e - 1;
            keep = q >> 2;
            g    = q[1];
            st   = q[0] || (r != 0);
        end
`ifdef FP32_DIV_RNE_EN
        if (g && (st || keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = 64'd1 << 23;
            e    = e + 1;
        end
`else
        if (g && st) keep = keep;  // truncation discards guard/sticky
`endif
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0)   return {3'b001, s, 31'd0};
        return {3'b000, s, e[7:0], keep[22:0]};
    endfunction

    // Runs one operation. Optional mid-operation start (restart_at>0) and
    // reset (rst_at>0). Cycle c is the c-th cycle after the accept edge,
    // sampled at the falling edge.
    task automatic run_op(
        input  logic [31:0] a, input logic [31:0] b,
        input  int restart_at, input logic [31:0] ra, input logic [31:0] rb,
        input  int rst_at,
        output logic [31:0] r_out, output logic [2:0] r_flags,
        output int lat, output int ndone,
        output logic busy_c1, output logic busy_done,
        output logic [2:0] flags_c1, output logic [31:0] out_c1,
        output logic zero_rst);
        r_out = 32'd0; r_flags = 3'd0; lat = -1; ndone = 0;
        busy_c1 = 1'b0; busy_done = 1'b1; flags_c1 = 3'd0; out_c1 = 32'd0;
        zero_rst = 1'b0;
        @(negedge clk);
        inp1 = a; inp2 = b; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) begin inp1 = ra; inp2 = rb; end
            if (c == 1) begin
                busy_c1  = busy;
                flags_c1 = {div_by_zero, overflow, underflow};
                out_c1   = out;
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                zero_rst = (out === 32'd0) && (busy === 1'b0) && (done === 1'b0) &&
                           ({div_by_zero, overflow, underflow} === 3'b000);
                rst = 1'b0;
            end
            if (c == rst_at) rst = 1'b1;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat       = c;
                    r_out     = out;
                    r_flags   = {div_by_zero, overflow, underflow};
                    busy_done = busy;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out, busy, done, div_by_zero, overflow, underflow} !== 36'd0)
            $display("FAIL reset_outputs: got out=%h busy=%b done=%b flags=%b%b%b, want all 0",
                     out, busy, done, div_by_zero, overflow, underflow);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [0:12];
        logic [31:0] vb [0:12];
        logic [31:0] vx [0:12];
        logic [2:0]  vf [0:12];
        logic [31:0] r_out, out_c1; logic [2:0] r_flags, flags_c1;
        int lat, ndone; logic bc1, bd, zr;
        va = '{32'h40200000, 32'h40C00000, 32'h3F800000, 32'h7F000000, 32'h00800000,
               32'hC0000000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'hFFC00001,
               32'h7F800000, 32'h80000000, 32'h3F800000};
        vb = '{32'h40200000, 32'h3FC00000, 32'h40400000, 32'h3E800000, 32'h40000000,
               32'h00000000, 32'h00000000, 32'h7F800000, 32'h40000000, 32'h3F800000,
               32'hFF800000, 32'h3F800000, 32'hBF800000};
`ifdef FP32_DIV_RNE_EN
        vx[2] = 32'h3EAAAAAB;
`else
        vx[2] = 32'h3EAAAAAA;
`endif
        vx[0] = 32'h3F800000; vx[1] = 32'h40800000; vx[3] = 32'h7F800000;
        vx[4] = 32'h00000000; vx[5] = 32'hFF800000; vx[6] = 32'h7FC00000;
        vx[7] = 32'h00000000; vx[8] = 32'h7F800000; vx[9] = 32'h7FC00000;
        vx[10] = 32'h7FC00000; vx[11] = 32'h80000000; vx[12] = 32'hBF800000;
        vf = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000,
               3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 13; i++) begin
            run_op(va[i], vb[i], 0, 32'd0, 32'd0, 0,
                   r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
            n_checks++;
            if (r_out !== vx[i]) $display("FAIL dir%0d_out: got %h want %h", i, r_out, vx[i]);
            else n_pass++;
            n_checks++;
            if (r_flags !== vf[i]) $display("FAIL dir%0d_flags(dbz,ovf,unf): got %b want %b", i, r_flags, vf[i]);
            else n_pass++;
            n_checks++;
            if (lat != LATENCY) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LATENCY);
            else n_pass++;
            n_checks++;
            if (ndone != 1) $display("FAIL dir%0d_done_count: got %0d want 1", i, ndone);
            else n_pass++;
            n_checks++;
            if (bc1 !== 1'b1 || bd !== 1'b0)
                $display("FAIL dir%0d_busy: got cycle1=%b done_cycle=%b want 1/0", i, bc1, bd);
            else n_pass++;
        end
    endtask

    // Flags clear on accept while out keeps the previous result.
    task automatic test_hold();
        logic [31:0] r_out, out_c1; logic [2:0] r_flags, flags_c1;
        int lat, ndone; logic bc1, bd, zr;
        run_op(32'h7F000000, 32'h3E800000, 0, 32'd0, 32'd0, 0,
               r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
        run_op(32'h40200000, 32'h40200000, 0, 32'd0, 32'd0, 0,
               r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
        n_checks++;
        if (flags_c1 !== 3'b000) $display("FAIL hold_flags_cleared: got %b want 000", flags_c1);
        else n_pass++;
        n_checks++;
        if (out_c1 !== 32'h7F800000) $display("FAIL hold_out_kept: got %h want 7f800000", out_c1);
        else n_pass++;
        n_checks++;
        if (r_out !== 32'h3F800000) $display("FAIL hold_next_result: got %h want 3f800000", r_out);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        logic [31:0] r_out, out_c1; logic [2:0] r_flags, flags_c1;
        int lat, ndone; logic bc1, bd, zr;
        run_op(32'h40200000, 32'h40200000, 5, 32'h40C00000, 32'h3FC00000, 0,
               r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
        n_checks++;
        if (r_out !== 32'h3F800000) $display("FAIL ignore_start_out: got %h want 3f800000", r_out);
        else n_pass++;
        n_checks++;
        if (lat != LATENCY) $display("FAIL ignore_start_latency: got %0d want %0d", lat, LATENCY);
        else n_pass++;
        n_checks++;
        if (ndone != 1) $display("FAIL ignore_start_done_count: got %0d want 1", ndone);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r_out, out_c1; logic [2:0] r_flags, flags_c1;
        int lat, ndone; logic bc1, bd, zr;
        run_op(32'h40C00000, 32'h3FC00000, 0, 32'd0, 32'd0, 0,
               r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
        run_op(32'h7F000000, 32'h3E800000, 0, 32'd0, 32'd0, 10,
               r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
        n_checks++;
        if (zr !== 1'b1) $display("FAIL reset_mid_outputs_zero: got %b want 1", zr);
        else n_pass++;
        n_checks++;
        if (ndone != 0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", ndone);
        else n_pass++;
        run_op(32'h40C00000, 32'h3FC00000, 0, 32'd0, 32'd0, 0,
               r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
        n_checks++;
        if (r_out !== 32'h40800000 || lat != LATENCY || ndone != 1)
            $display("FAIL reset_mid_recovery: got out=%h lat=%0d pulses=%0d want 40800000/%0d/1",
                     r_out, lat, ndone, LATENCY);
        else n_pass++;
    endtask

    function automatic logic [31:0] rand_operand();
        int unsigned r;
        logic [7:0]  e;
        logic [22:0] m;
        r = $urandom_range(0, 19);
        m = 23'($urandom);
        if (r == 0)      e = 8'd0;
        else if (r == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = 23'd0; end
        else if (r < 7)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(64, 190));
        return {1'($urandom), e, m};
    endfunction

    task automatic test_random();
        logic [31:0] a, b, r_out, out_c1; logic [2:0] r_flags, flags_c1;
        logic [34:0] exp_v;
        int lat, ndone; logic bc1, bd, zr;
        for (int i = 0; i < 250; i++) begin
            a = rand_operand();
            b = rand_operand();
            exp_v = model(a, b);
            run_op(a, b, 0, 32'd0, 32'd0, 0,
                   r_out, r_flags, lat, ndone, bc1, bd, flags_c1, out_c1, zr);
            n_checks++;
            if (r_out !== exp_v[31:0] || r_flags !== exp_v[34:32])
                $display("FAIL rand%0d %h/%h: got out=%h flags=%b want out=%h flags=%b",
                         i, a, b, r_out, r_flags, exp_v[31:0], exp_v[34:32]);
            else n_pass++;
            n_checks++;
            if (lat != LATENCY || ndone != 1)
                $display("FAIL rand%0d_timing: got lat=%0d pulses=%0d want %0d/1", i, lat, ndone, LATENCY);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
